// File: rtl/piggy_pkg.sv
// Shared definitions for the piggy bank serial link: receiver states, host
// command characters and the baud divider both UART ends must agree on.
package piggy_pkg;

  // 10 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 87;

  localparam logic [7:0] CMD_REPORT = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C'

  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } rx_state_t;

  // Upper-case command letter or its lower-case form
  function automatic logic cmd_match(input logic [7:0] rx_byte, input logic [7:0] cmd);
    return (rx_byte == cmd) || (rx_byte == (cmd | ASCII_CASE_BIT));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. The reset value is a
// parameter so an idle-high line never looks active while in reset.
module sync_2ff #(
  parameter int         WIDTH   = 1,
  parameter logic [0:0] RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/piggy_uart_rx_cmd.sv
// UART 8N1 receiver for host commands: rebuilds bytes from the serial line,
// flags bad stop bits and turns 'S'/'C' (either case) into one-cycle strobes.
//
// state   | meaning
// IDLE    | line idle, counters held at 0, waiting for a low sample
// START   | wait to the middle of the start bit, abort if the line went high
// DATA    | sample eight data bits LSB first, one per bit period
// STOP    | sample the stop bit, publish the byte or flag a framing error
// CLEANUP | single cycle before returning to IDLE
module piggy_uart_rx_cmd
  import piggy_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] CMD_REPORT   = piggy_pkg::CMD_REPORT,
  parameter logic [7:0] CMD_CLEAR    = piggy_pkg::CMD_CLEAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Data,
  output logic       o_Rx_DV,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active,
  output logic       o_Cmd_Report,
  output logic       o_Cmd_Clear
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_Rx_Serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      o_Rx_Data      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
      o_Cmd_Report   <= 1'b0;
      o_Cmd_Clear    <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Cmd_Report   <= 1'b0;
      o_Cmd_Clear    <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state       <= START;
            o_Rx_Active <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Low pulse shorter than half a bit: treat as line noise
              state       <= IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt     <= '0;
            state       <= CLEANUP;
            o_Rx_Active <= 1'b0;
            if (rx_s) begin
              o_Rx_Data    <= shift_reg;
              o_Rx_DV      <= 1'b1;
              o_Cmd_Report <= cmd_match(shift_reg, CMD_REPORT);
              o_Cmd_Clear  <= cmd_match(shift_reg, CMD_CLEAR);
            end else begin
              o_Rx_Frame_Err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        CLEANUP: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piggy_uart_rx_cmd.sv
// Directed bench for the host command receiver: reset, valid commands,
// back-to-back bytes, framing error, start glitch and mid-frame reset.
module tb_piggy_uart_rx_cmd;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_Rx_Data;
  logic       o_Rx_DV;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;
  logic       o_Cmd_Report;
  logic       o_Cmd_Clear;

  always #5 clk = ~clk;

  piggy_uart_rx_cmd #(
    .CLKS_PER_BIT (CPB),
    .CMD_REPORT   (8'h53),
    .CMD_CLEAR    (8'h43)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_Data      (o_Rx_Data),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Active    (o_Rx_Active),
    .o_Cmd_Report   (o_Cmd_Report),
    .o_Cmd_Clear    (o_Cmd_Clear)
  );

  // Event monitor, sampled on the falling edge away from DUT updates
  int         dv_cnt  = 0;
  int         fe_cnt  = 0;
  int         rep_cnt = 0;
  int         clr_cnt = 0;
  int         bad_cnt = 0;
  int         act_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] fe_data   = 8'h00;
  logic       dv_q      = 1'b0;
  logic [7:0] data_q[$];

  always @(negedge clk) begin
    if (o_Rx_DV === 1'b1) begin
      dv_cnt++;
      last_data = o_Rx_Data;
      data_q.push_back(o_Rx_Data);
    end
    if (o_Rx_Frame_Err === 1'b1) begin
      fe_cnt++;
      fe_data = o_Rx_Data;
    end
    if (o_Cmd_Report === 1'b1) rep_cnt++;
    if (o_Cmd_Clear === 1'b1) clr_cnt++;
    if ((o_Rx_DV === 1'b1 && o_Rx_Frame_Err === 1'b1) ||
        (o_Rx_DV === 1'b1 && dv_q) ||
        ((o_Cmd_Report === 1'b1 || o_Cmd_Clear === 1'b1) && o_Rx_DV !== 1'b1) ||
        (o_Cmd_Report === 1'b1 && o_Cmd_Clear === 1'b1))
      bad_cnt++;
    dv_q = (o_Rx_DV === 1'b1);
    if (o_Rx_Active === 1'b1) act_cyc++;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int s_dv, s_fe, s_rep, s_clr, s_act;

  task automatic snap();
    s_dv  = dv_cnt;
    s_fe  = fe_cnt;
    s_rep = rep_cnt;
    s_clr = clr_cnt;
    s_act = act_cyc;
  endtask

  task automatic expect_events(input string tag, input int dv, input int fe,
                               input int rep, input int clr);
    check({tag, ".dv"},  32'(dv_cnt - s_dv),   32'(dv));
    check({tag, ".fe"},  32'(fe_cnt - s_fe),   32'(fe));
    check({tag, ".rep"}, 32'(rep_cnt - s_rep), 32'(rep));
    check({tag, ".clr"}, 32'(clr_cnt - s_clr), 32'(clr));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d passed=%0d", total, passed);
    $fatal(1, "timeout");
  end

  int q_snap;

  initial begin
    // Reset with idle line
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst.data",   32'(o_Rx_Data),      32'h00);
    check("rst.dv",     32'(o_Rx_DV),        32'h0);
    check("rst.fe",     32'(o_Rx_Frame_Err), 32'h0);
    check("rst.active", 32'(o_Rx_Active),    32'h0);
    check("rst.rep",    32'(o_Cmd_Report),   32'h0);
    check("rst.clr",    32'(o_Cmd_Clear),    32'h0);
    rst = 1'b0;
    snap();
    repeat (20 * CPB) @(negedge clk);
    expect_events("idle", 0, 0, 0, 0);
    check("idle.act", 32'(act_cyc - s_act), 32'd0);

    // 'S': start half bit (44) + 8 data bits + stop bit of active time
    snap();
    send_byte(8'h53, 1'b1);
    repeat (20) @(negedge clk);
    expect_events("S", 1, 0, 1, 0);
    check("S.data", 32'(last_data), 32'h53);
    check("S.act",  32'(act_cyc - s_act), 32'd827);

    // Lower-case 'c'
    snap();
    send_byte(8'h63, 1'b1);
    repeat (20) @(negedge clk);
    expect_events("c", 1, 0, 0, 1);
    check("c.data", 32'(last_data), 32'h63);

    // 'C' with a low stop bit: framing error, data register untouched
    snap();
    send_byte(8'h43, 1'b0);
    repeat (300) @(negedge clk);
    expect_events("ferr", 0, 1, 0, 0);
    check("ferr.data_at_strobe", 32'(fe_data), 32'h63);
    check("ferr.data_after",     32'(o_Rx_Data), 32'h63);

    // Back-to-back non-command bytes
    snap();
    q_snap = data_q.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    expect_events("b2b", 2, 0, 0, 0);
    check("b2b.first",  32'((data_q.size() > q_snap)     ? data_q[q_snap]     : 8'hxx), 32'hA5);
    check("b2b.second", 32'((data_q.size() > q_snap + 1) ? data_q[q_snap + 1] : 8'hxx), 32'h00);

    // 20-clock glitch: START aborts at half bit
    snap();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    expect_events("glitch", 0, 0, 0, 0);
    check("glitch.act", 32'(act_cyc - s_act), 32'd44);
    snap();
    send_byte(8'h53, 1'b1);
    repeat (20) @(negedge clk);
    expect_events("S2", 1, 0, 1, 0);
    check("S2.data", 32'(last_data), 32'h53);

    // Reset during data bit 4 of 'S'; host then abandons the frame
    snap();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h53 >> i) & 8'h01) != 8'h00;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("mid.active_before", 32'(o_Rx_Active), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid.data",   32'(o_Rx_Data),   32'h00);
    check("mid.active", 32'(o_Rx_Active), 32'h0);
    check("mid.dv",     32'(o_Rx_DV),     32'h0);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    expect_events("mid", 0, 0, 0, 0);
    snap();
    send_byte(8'h43, 1'b1);
    repeat (20) @(negedge clk);
    expect_events("C", 1, 0, 0, 1);
    check("C.data", 32'(last_data), 32'h43);

    // Strobe exclusivity and one-cycle width over the whole run
    check("strobe_rules", 32'(bad_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
